// File: rtl/ber_checker_pkg.sv
// Shared definitions for the BER checker: acquisition state encoding and the
// default geometry constants also used by the VIO register map.
package ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int DEF_DEPTH    = 512;
  localparam int DEF_WINDOW   = 511;
  localparam int DEF_THRESH   = 127;
  localparam int DEF_CNT_BITS = 64;

endpackage

// File: rtl/ber_checker_ref_delay_line.sv
// Reference bit history with a selectable tap; tap 0 is the live input bit,
// tap k is the bit presented k enabled shifts earlier.
module ber_checker_ref_delay_line #(
  parameter int DEPTH    = 512,
  parameter int SEL_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                din_i,
  input  logic [SEL_BITS-1:0] sel_i,
  output logic                tap_o
);

  // Tap DEPTH-1 is the oldest reachable bit, so DEPTH-1 stored bits suffice.
  logic [DEPTH-2:0] hist_q;
  logic [DEPTH-2:0] hist_d;
  logic [DEPTH-1:0] taps;

  always_comb begin
    hist_d = hist_q;
    if (en_i) begin
      hist_d = {hist_q[DEPTH-3:0], din_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign taps  = {hist_q, din_i};
  assign tap_o = taps[sel_i];

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: finds the rx latency against the reference PRBS by
// exhaustive offset search, then counts compared bits and errors.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int THRESH   = DEF_THRESH,
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int OFF_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_rx_bit,
  input  logic                i_ref_bit,
  input  logic                i_restart,
  output logic                o_locked,
  output logic                o_search_busy,
  output logic [OFF_BITS-1:0] o_offset,
  output logic [CNT_BITS-1:0] o_bit_count,
  output logic [CNT_BITS-1:0] o_err_count
);

  localparam int ERR_W = $clog2(WINDOW + 1);
  localparam logic [OFF_BITS-1:0] FILL_LAST = OFF_BITS'(DEPTH - 2);
  localparam logic [OFF_BITS-1:0] CAND_LAST = OFF_BITS'(DEPTH - 1);
  localparam logic [ERR_W-1:0]    WIN_LAST  = ERR_W'(WINDOW);
  localparam logic [ERR_W-1:0]    THRESH_W  = ERR_W'(THRESH);

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] fill_cnt_q, fill_cnt_d;
  logic [OFF_BITS-1:0] cand_q, cand_d;
  logic [ERR_W-1:0]    win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]    err_acc_q, err_acc_d;
  logic [ERR_W-1:0]    best_err_q, best_err_d;
  logic [OFF_BITS-1:0] best_off_q, best_off_d;
  logic [OFF_BITS-1:0] offset_q, offset_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                restart;
  logic [OFF_BITS-1:0] tap_sel;
  logic                tap_bit;
  logic                cmp_bit;
  logic [ERR_W-1:0]    err_sum;
  logic [ERR_W-1:0]    win_next;
  logic [ERR_W-1:0]    cand_best_err;
  logic [OFF_BITS-1:0] cand_best_off;

  // A disabled cycle freezes everything, restart included.
  assign accept  = i_valid & i_enable & ~i_restart;
  assign restart = i_enable & i_restart;
  assign tap_sel = (state_q == ST_LOCKED) ? offset_q : cand_q;
  assign cmp_bit = i_rx_bit ^ tap_bit;

  ber_checker_ref_delay_line #(
    .DEPTH    (DEPTH),
    .SEL_BITS (OFF_BITS)
  ) u_ref_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (accept),
    .din_i (i_ref_bit),
    .sel_i (tap_sel),
    .tap_o (tap_bit)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    cand_d     = cand_q;
    win_cnt_d  = win_cnt_q;
    err_acc_d  = err_acc_q;
    best_err_d = best_err_q;
    best_off_d = best_off_q;
    offset_d   = offset_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;

    err_sum       = err_acc_q + ERR_W'(cmp_bit);
    win_next      = win_cnt_q + ERR_W'(1);
    cand_best_err = best_err_q;
    cand_best_off = best_off_q;
    // Strict compare keeps the lowest offset on ties.
    if (err_sum < best_err_q) begin
      cand_best_err = err_sum;
      cand_best_off = cand_q;
    end

    if (restart) begin
      state_d    = ST_FILL;
      fill_cnt_d = '0;
      cand_d     = '0;
      win_cnt_d  = '0;
      err_acc_d  = '0;
      best_err_d = '1;
      best_off_d = '0;
      offset_d   = '0;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
    end else if (accept) begin
      case (state_q)
        ST_FILL: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_d    = ST_SEARCH;
            fill_cnt_d = '0;
            cand_d     = '0;
            win_cnt_d  = '0;
            err_acc_d  = '0;
            best_err_d = '1;
            best_off_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + OFF_BITS'(1);
          end
        end
        ST_SEARCH: begin
          if (win_next == WIN_LAST) begin
            win_cnt_d = '0;
            err_acc_d = '0;
            if (cand_q == CAND_LAST) begin
              // Sweep finished: lock on the best window or sweep again.
              cand_d = '0;
              if (cand_best_err <= THRESH_W) begin
                state_d  = ST_LOCKED;
                offset_d = cand_best_off;
              end
              best_err_d = '1;
              best_off_d = '0;
            end else begin
              cand_d     = cand_q + OFF_BITS'(1);
              best_err_d = cand_best_err;
              best_off_d = cand_best_off;
            end
          end else begin
            win_cnt_d = win_next;
            err_acc_d = err_sum;
          end
        end
        ST_LOCKED: begin
          if (!(&bit_cnt_q)) begin
            bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
          end
          if (cmp_bit && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_BITS'(1);
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    busy_d   = (state_d != ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      cand_q     <= '0;
      win_cnt_q  <= '0;
      err_acc_q  <= '0;
      best_err_q <= '1;
      best_off_q <= '0;
      offset_q   <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      cand_q     <= cand_d;
      win_cnt_q  <= win_cnt_d;
      err_acc_q  <= err_acc_d;
      best_err_q <= best_err_d;
      best_off_q <= best_off_d;
      offset_q   <= offset_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_search_busy = busy_q;
  assign o_offset      = offset_q;
  assign o_bit_count   = bit_cnt_q;
  assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: PRBS9 acquisition, locked counting,
// enable freeze, restart, async reset and counter saturation.
module tb_ber_checker;

  localparam int DEPTH    = 16;
  localparam int WINDOW   = 15;
  localparam int THRESH   = 3;
  localparam int CNT_BITS = 16;
  localparam int OFF_BITS = 4;
  localparam int ACQ      = (DEPTH - 1) + DEPTH * WINDOW;
  localparam int DELAY    = 5;
  localparam int SMAX     = 15;

  logic clk = 1'b0;
  logic reset;
  logic i_enable, i_valid, i_rx_bit, i_ref_bit, i_restart;
  logic                o_locked, o_search_busy;
  logic [OFF_BITS-1:0] o_offset;
  logic [CNT_BITS-1:0] o_bit_count, o_err_count;
  logic                s_locked, s_search_busy;
  logic [OFF_BITS-1:0] s_offset;
  logic [3:0]          s_bit_count, s_err_count;

  always #5 clk = ~clk;

  ber_checker #(.DEPTH(DEPTH), .WINDOW(WINDOW), .THRESH(THRESH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .i_restart(i_restart),
    .o_locked(o_locked), .o_search_busy(o_search_busy), .o_offset(o_offset),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  // Narrow-counter copy on the same inputs so saturation is reachable quickly.
  ber_checker #(.DEPTH(DEPTH), .WINDOW(WINDOW), .THRESH(THRESH), .CNT_BITS(4)) dut_sat (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .i_restart(i_restart),
    .o_locked(s_locked), .o_search_busy(s_search_busy), .o_offset(s_offset),
    .o_bit_count(s_bit_count), .o_err_count(s_err_count)
  );

  typedef struct packed {
    logic                locked;
    logic [OFF_BITS-1:0] off;
    logic [31:0]         bits;
    logic [31:0]         errs;
  } exp_t;

  typedef struct {
    logic en;
    logic vld;
    logic rst;
    logic flip;
    logic expLocked;
    int   expBits;
    int   expErrs;
  } vec_t;

  exp_t        sbQ[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] txHist;
  logic [8:0]  lfsr;
  logic        altBit;
  logic        rxConst, refAlt, lockExpected, mLocked;
  int          mBits, mErrs, acqCnt, n;
  logic        v;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] satSmall(input logic [31:0] x);
    return (x > 32'(SMAX)) ? 64'(SMAX) : 64'(x);
  endfunction

  task automatic modelReset();
    mLocked = 1'b0;
    mBits   = 0;
    mErrs   = 0;
    acqCnt  = 0;
    txHist  = '0;
  endtask

  // Drives one cycle, updates the reference model, pushes the expected outputs
  // and compares them against the DUT one edge later.
  task automatic applyStimulus(input logic en, input logic vld, input logic rst, input logic flip);
    logic acc, r, rx, tapBit;
    exp_t e;
    acc = en & vld & ~rst;
    if (acc) begin
      r  = refAlt ? altBit : lfsr[8];
      rx = (rxConst ? 1'b1 : txHist[DELAY-1]) ^ flip;
    end else begin
      r  = 1'($urandom());
      rx = 1'($urandom());
    end
    i_enable  = en;
    i_valid   = vld;
    i_restart = rst;
    i_ref_bit = r;
    i_rx_bit  = rx;
    if (en && rst) begin
      mLocked = 1'b0;
      mBits   = 0;
      mErrs   = 0;
      acqCnt  = 0;
    end else if (acc) begin
      if (mLocked) begin
        tapBit = txHist[DELAY-1];
        mBits++;
        mErrs += int'(rx ^ tapBit);
      end else begin
        acqCnt++;
        if (acqCnt == ACQ && lockExpected) mLocked = 1'b1;
      end
      if (refAlt) altBit = ~altBit;
      else lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      txHist = {txHist[62:0], r};
    end
    e.locked = mLocked;
    e.off    = mLocked ? OFF_BITS'(DELAY) : '0;
    e.bits   = 32'(mBits);
    e.errs   = 32'(mErrs);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sbQ.pop_front();
      checkOutput("sb_locked", 64'(o_locked), 64'(e.locked));
      checkOutput("sb_busy", 64'(o_search_busy), 64'(!e.locked));
      checkOutput("sb_offset", 64'(o_offset), 64'(e.off));
      checkOutput("sb_bit_count", 64'(o_bit_count), 64'(e.bits));
      checkOutput("sb_err_count", 64'(o_err_count), 64'(e.errs));
      checkOutput("sb_sat_locked", 64'(s_locked), 64'(e.locked));
      checkOutput("sb_sat_bit_count", 64'(s_bit_count), satSmall(e.bits));
      checkOutput("sb_sat_err_count", 64'(s_err_count), satSmall(e.errs));
    end
    i_valid   = 1'b0;
    i_restart = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_locked"}, 64'(o_locked), 64'(0));
    checkOutput({tag, "_busy"}, 64'(o_search_busy), 64'(1));
    checkOutput({tag, "_offset"}, 64'(o_offset), 64'(0));
    checkOutput({tag, "_bits"}, 64'(o_bit_count), 64'(0));
    checkOutput({tag, "_errs"}, 64'(o_err_count), 64'(0));
    checkOutput({tag, "_sat_bits"}, 64'(s_bit_count), 64'(0));
  endtask

  initial begin
    // Locked-state vectors starting from 218 bits / 18 errors.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 219, 18};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 220, 19};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 220, 19};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 220, 19};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 221, 19};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};

    reset = 1'b1;
    i_enable = 1'b0; i_valid = 1'b0; i_rx_bit = 1'b0; i_ref_bit = 1'b0; i_restart = 1'b0;
    lfsr = 9'h1FF; altBit = 1'b0;
    rxConst = 1'b0; refAlt = 1'b0; lockExpected = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset_init");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] acquisition, PRBS9 with rx delayed %0d", DELAY);
    n = 0;
    for (int c = 0; c < 600 && !o_locked; c++) begin
      v = ((c % 4) != 3);
      applyStimulus(1'b1, v, 1'b0, 1'b0);
      if (v) n++;
    end
    checkOutput("acq_symbols", 64'(n), 64'(ACQ));
    checkOutput("acq_offset", 64'(o_offset), 64'(DELAY));

    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clean_bits", 64'(o_bit_count), 64'(100));
    checkOutput("clean_errs", 64'(o_err_count), 64'(0));

    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, 1'b0, (i % 10) == 9);
    checkOutput("flip10_bits", 64'(o_bit_count), 64'(200));
    checkOutput("flip10_errs", 64'(o_err_count), 64'(10));

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("burst_errs", 64'(o_err_count), 64'(18));
    checkOutput("sat_bits", 64'(s_bit_count), 64'(15));
    checkOutput("sat_errs", 64'(s_err_count), 64'(15));

    $display("[TB] enable freeze");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, (i % 3) == 0);
    checkOutput("freeze_bits", 64'(o_bit_count), 64'(208));
    checkOutput("freeze_errs", 64'(o_err_count), 64'(18));
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_bits", 64'(o_bit_count), 64'(218));
    checkOutput("resume_errs", 64'(o_err_count), 64'(18));

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].rst, vecs[i].flip);
      checkOutput($sformatf("vec%0d_locked", i), 64'(o_locked), 64'(vecs[i].expLocked));
      checkOutput($sformatf("vec%0d_bits", i), 64'(o_bit_count), 64'(vecs[i].expBits));
      checkOutput($sformatf("vec%0d_errs", i), 64'(o_err_count), 64'(vecs[i].expErrs));
    end

    $display("[TB] re-acquisition after restart");
    n = 0;
    for (int c = 0; c < 400 && !o_locked; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("relock_symbols", 64'(n), 64'(ACQ - 1));
    checkOutput("relock_offset", 64'(o_offset), 64'(DELAY));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("relock_bits", 64'(o_bit_count), 64'(5));

    #2;
    reset = 1'b1;
    #1;
    checkResetState("reset_locked");
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    $display("[TB] constant rx, no lock expected");
    rxConst = 1'b1; refAlt = 1'b1; lockExpected = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if ((i % 100) == 99) checkOutput("nolock_busy", 64'(o_search_busy), 64'(1));
      if (i == 500) begin
        #2;
        reset = 1'b1;
        #1;
        checkResetState("reset_search");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Bit-error-rate checker directly downstream of the receive matched filter/slicer.
- Consumes the detected bit stream, one bit per symbol strobe, and compares it with the transmitter's reference PRBS bit stream.
- Finds the unknown channel+filter latency by exhaustive offset search, then locks and accumulates bit and error counts for readout (VIO/register bank).

Parameters:
- DEPTH, 512, reference history length in bits; searchable offsets are 0..DEPTH-1.
- WINDOW, 511, number of compared bits per candidate offset during search.
- THRESH, 127, maximum window errors accepted as a valid lock.
- CNT_BITS, 64, width of the bit and error counters.
- OFF_BITS, $clog2(DEPTH), width of the offset field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global run enable, same signal that gates the rx filter; low = freeze all state.
- i_valid  in  1  symbol strobe, one-cycle pulse per detected symbol.
- i_rx_bit  in  1  detected bit from the slicer, valid when i_valid.
- i_ref_bit  in  1  transmitted reference bit, valid when i_valid.
- i_restart  in  1  pulse; abandon the current state and re-acquire.
- o_locked  out  1  offset found, counting active.
- o_search_busy  out  1  in FILL or SEARCH.
- o_offset  out  OFF_BITS  selected latency in symbols.
- o_bit_count  out  CNT_BITS  compared bits since lock.
- o_err_count  out  CNT_BITS  errors since lock.

Behaviour:
- Reset (async): state=FILL, o_locked=0, o_search_busy=1, o_offset=0, both counters 0, reference history 0.
- Accepted symbol = i_valid & i_enable & ~i_restart. Only accepted symbols advance any state.
- Reference history:
  - On each accepted symbol, shift i_ref_bit into a DEPTH-bit register.
  - tap(k) = the reference bit presented k accepted symbols earlier; tap(0) = the current i_ref_bit.
  - The comparison bit is i_rx_bit XOR tap(k).
- i_enable low: every register holds (including history and counters), regardless of i_valid.
- i_restart (sampled at the clock edge, wins over a same-cycle i_valid):
  - Next state FILL; counters, o_locked and o_offset cleared.
  - History is not cleared.
- FILL:
  - Count DEPTH-1 accepted symbols so that every tap is populated.
  - Then go to SEARCH with cand=0, win_cnt=0, err_acc=0, best_err=all-ones, best_off=0.
- SEARCH:
  - Each accepted symbol: err_acc += i_rx_bit ^ tap(cand); win_cnt++.
  - When win_cnt reaches WINDOW:
    - If err_acc < best_err (strict, so the lowest offset wins ties), update best_err/best_off.
    - Clear err_acc and win_cnt; cand++.
  - The symbol that completes the window is included in that window's err_acc.
  - After the window for cand=DEPTH-1 completes:
    - If best_err <= THRESH: go to LOCKED, o_offset=best_off.
    - Else: re-enter SEARCH with cand=0 and best_err reset. FILL is not repeated.
  - err_acc width is $clog2(WINDOW+1). best_err must hold the all-ones sentinel.
- LOCKED:
  - Each accepted symbol: o_bit_count++, o_err_count += i_rx_bit ^ tap(o_offset).
  - Both counters saturate at all-ones; no wrap.
  - No automatic loss-of-lock; re-acquisition only via i_restart or reset.
- Output timing:
  - All outputs are registered; counter updates are visible the cycle after the accepted strobe.
  - o_locked rises in the cycle after the last search symbol.
  - o_search_busy = (state != LOCKED).
- Full acquisition time: (DEPTH-1) + DEPTH*WINDOW accepted symbols.
- Mid-operation reset: immediate return to reset values, asynchronous to clk.

Decomposition:
- Shared package (rx_pkg): state encoding FILL/SEARCH/LOCKED and the default DEPTH/WINDOW/THRESH constants, shared with the VIO register map.
- One natural sub-module, ref_delay_line:
  - DEPTH-bit shift register with enable.
  - Combinational mux giving tap(sel); sel=0 returns the live input bit.
  - Instantiated twice only if a future dual-lane variant is needed; the top holds the FSM and counters.

Test Plan (DEPTH=16, WINDOW=15, THRESH=3, CNT_BITS=16 unless stated):
1. Assert reset mid-SEARCH -> within the same cycle o_locked=0, o_search_busy=1, o_offset=0, counters 0.
2. PRBS9 reference, rx = reference delayed 5 symbols, error-free -> o_locked=1 after exactly 15+16*15=255 accepted symbols, o_offset=5. 100 further symbols -> o_bit_count=100, o_err_count=0.
3. Case 2 after lock, flip every 10th rx bit -> after 100 symbols o_bit_count=100, o_err_count=10.
4. rx held at constant 1 (≈50% errors) -> best_err>3, o_locked stays 0, search repeats, o_search_busy stays 1 for 1000 symbols.
5. Locked, pulse i_restart coincident with i_valid -> next cycle o_locked=0, counters 0, that symbol ignored. Re-lock occurs after another 255 accepted symbols with the same offset.
6. Locked, i_enable=0 for 20 cycles while i_valid toggles -> counters and history unchanged. Re-enable -> counting resumes with o_err_count still 0.
